// File: rtl/sodor5_itype_ref_exec.sv
// -----------------------------------------------------------------------------
// sodor5_itype_ref_exec
//
// Golden reference executor for the RV32I OP-IMM instruction stream that is
// driven into the sodor5 core. It decodes ADDI/SLTI/SLTIU/XORI/ORI/ANDI/SLLI/
// SRLI/SRAI against a shadow 32x32 register file. It produces one commit record
// per accepted instruction, so the core's writeback can be compared with it.
//
// Pipeline
//   S1 : holds the raw instruction. It decodes it and executes it
//        combinationally, again on every cycle, so a stalled S1 always sees
//        the freshest operand.
//   S2 : holds the commit record that is presented on the commit_* outputs.
//
// Handshake semantics (both sides follow strict valid/ready)
//   A transfer happens on a rising clk edge when valid and ready are both high.
//   Valid never depends on ready. instr_ready depends combinationally on
//   commit_ready, so a full pipeline can still take a new instruction on the
//   same edge that S2 drains. There is no combinational path from instr_valid
//   to any output.
//
// Ports
//   clk            in   1      clock, all state updates on posedge
//   reset          in   1      synchronous, active-high; does not clear regfile
//   instr_valid    in   1      instr holds an instruction to execute
//   instr          in   32     raw instruction word
//   instr_ready    out  1      instruction accepted on this edge if instr_valid
//   rf_init_we     in   1      shadow regfile seeding write enable
//   rf_init_addr   in   5      shadow regfile seeding index (x0 ignored)
//   rf_init_data   in   XLEN   shadow regfile seeding data
//   commit_valid   out  1      S2 holds a commit record
//   commit_ready   in   1      consumer takes the record on this edge
//   commit_rd      out  5      destination index, instr[11:7]
//   commit_wdata   out  XLEN   result; 0 when rd==0 or the instruction is illegal
//   commit_illegal out  1      instruction is not a legal OP-IMM
//   commit_count   out  CNT_W  number of records consumed, wraps
// -----------------------------------------------------------------------------
module sodor5_itype_ref_exec #(
    parameter int XLEN  = 32,   // only 32 is supported
    parameter int NREGS = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             instr_valid,
    input  logic [31:0]      instr,
    output logic             instr_ready,
    input  logic             rf_init_we,
    input  logic [4:0]       rf_init_addr,
    input  logic [XLEN-1:0]  rf_init_data,
    output logic             commit_valid,
    input  logic             commit_ready,
    output logic [4:0]       commit_rd,
    output logic [XLEN-1:0]  commit_wdata,
    output logic             commit_illegal,
    output logic [CNT_W-1:0] commit_count
);

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    localparam logic [2:0] F3_ADDI  = 3'd0;
    localparam logic [2:0] F3_SLLI  = 3'd1;
    localparam logic [2:0] F3_SLTI  = 3'd2;
    localparam logic [2:0] F3_SLTIU = 3'd3;
    localparam logic [2:0] F3_XORI  = 3'd4;
    localparam logic [2:0] F3_SRXI  = 3'd5;
    localparam logic [2:0] F3_ORI   = 3'd6;
    localparam logic [2:0] F3_ANDI  = 3'd7;

    localparam logic [6:0] HI7_ZERO = 7'b0000000;
    localparam logic [6:0] HI7_SRAI = 7'b0100000;

    typedef enum logic [3:0] {
        OP_ADDI,
        OP_SLTI,
        OP_SLTIU,
        OP_XORI,
        OP_ORI,
        OP_ANDI,
        OP_SLLI,
        OP_SRLI,
        OP_SRAI,
        OP_ILLEGAL
    } op_e;

    // -------------------------------------------------------------------------
    // Pipeline state
    // -------------------------------------------------------------------------
    logic            s1_valid;
    logic [31:0]     s1_instr;

    logic            s2_valid;
    logic [4:0]      s2_rd;
    logic [XLEN-1:0] s2_wdata;
    logic            s2_illegal;

    logic [XLEN-1:0] rf [NREGS];

    // -------------------------------------------------------------------------
    // Handshake
    // -------------------------------------------------------------------------
    logic s2_adv;
    logic s1_move;
    logic accept;
    logic fire;

    assign s2_adv      = !s2_valid || commit_ready;
    assign instr_ready = !s1_valid || s2_adv;
    assign accept      = instr_valid && instr_ready;
    assign fire        = s2_valid && commit_ready;
    assign s1_move     = s1_valid && s2_adv;

    // -------------------------------------------------------------------------
    // S1 field extraction
    // -------------------------------------------------------------------------
    logic [6:0]      s1_opcode;
    logic [4:0]      s1_rd;
    logic [2:0]      s1_funct3;
    logic [4:0]      s1_rs1;
    logic [6:0]      s1_hi7;
    logic [4:0]      s1_shamt;
    logic [XLEN-1:0] s1_imm;

    assign s1_opcode = s1_instr[6:0];
    assign s1_rd     = s1_instr[11:7];
    assign s1_funct3 = s1_instr[14:12];
    assign s1_rs1    = s1_instr[19:15];
    assign s1_hi7    = s1_instr[31:25];
    assign s1_shamt  = s1_instr[24:20];
    assign s1_imm    = {{(XLEN-12){s1_instr[31]}}, s1_instr[31:20]};

    // -------------------------------------------------------------------------
    // S1 decode: shift encodings are only legal with a clean upper immediate,
    // and for right shifts imm[10] alone distinguishes SRAI from SRLI.
    // -------------------------------------------------------------------------
    op_e s1_op;

    always_comb begin
        s1_op = OP_ILLEGAL;
        if (s1_opcode == OPC_OP_IMM) begin
            case (s1_funct3)
                F3_ADDI:  s1_op = OP_ADDI;
                F3_SLTI:  s1_op = OP_SLTI;
                F3_SLTIU: s1_op = OP_SLTIU;
                F3_XORI:  s1_op = OP_XORI;
                F3_ORI:   s1_op = OP_ORI;
                F3_ANDI:  s1_op = OP_ANDI;
                F3_SLLI: begin
                    if (s1_hi7 == HI7_ZERO) begin
                        s1_op = OP_SLLI;
                    end
                end
                F3_SRXI: begin
                    if (s1_hi7 == HI7_ZERO) begin
                        s1_op = OP_SRLI;
                    end else if (s1_hi7 == HI7_SRAI) begin
                        s1_op = OP_SRAI;
                    end
                end
                default: s1_op = OP_ILLEGAL;
            endcase
        end
    end

    logic s1_legal;
    assign s1_legal = (s1_op != OP_ILLEGAL);

    // -------------------------------------------------------------------------
    // S1 operand read. The only in-flight producer an S1 instruction can depend
    // on is the record sitting in S2; records that do not write the regfile
    // (illegal or rd==x0) must not be forwarded.
    // -------------------------------------------------------------------------
    logic [XLEN-1:0] s1_op_a;

    always_comb begin
        s1_op_a = '0;
        if (s1_rs1 == 5'd0) begin
            s1_op_a = '0;
        end else if (s2_valid && !s2_illegal && (s2_rd != 5'd0) && (s2_rd == s1_rs1)) begin
            s1_op_a = s2_wdata;
        end else begin
            s1_op_a = rf[s1_rs1];
        end
    end

    // -------------------------------------------------------------------------
    // S1 execute
    // -------------------------------------------------------------------------
    logic [XLEN-1:0] s1_alu;
    logic [XLEN-1:0] s1_wdata;

    always_comb begin
        s1_alu = '0;
        case (s1_op)
            OP_ADDI:  s1_alu = s1_op_a + s1_imm;
            OP_SLTI:  s1_alu = {{(XLEN-1){1'b0}}, ($signed(s1_op_a) < $signed(s1_imm))};
            OP_SLTIU: s1_alu = {{(XLEN-1){1'b0}}, (s1_op_a < s1_imm)};
            OP_XORI:  s1_alu = s1_op_a ^ s1_imm;
            OP_ORI:   s1_alu = s1_op_a | s1_imm;
            OP_ANDI:  s1_alu = s1_op_a & s1_imm;
            OP_SLLI:  s1_alu = s1_op_a << s1_shamt;
            OP_SRLI:  s1_alu = s1_op_a >> s1_shamt;
            OP_SRAI:  s1_alu = $unsigned($signed(s1_op_a) >>> s1_shamt);
            default:  s1_alu = '0;
        endcase
    end

    // The record carries 0 whenever it will not write the regfile, so the
    // consumer can compare wdata without first checking rd/illegal.
    assign s1_wdata = (s1_legal && (s1_rd != 5'd0)) ? s1_alu : '0;

    // -------------------------------------------------------------------------
    // Pipeline control and commit counter
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid     <= 1'b0;
            s2_valid     <= 1'b0;
            s2_rd        <= '0;
            s2_wdata     <= '0;
            s2_illegal   <= 1'b0;
            commit_count <= '0;
        end else begin
            if (accept) begin
                s1_valid <= 1'b1;
            end else if (s1_move) begin
                s1_valid <= 1'b0;
            end

            if (s1_move) begin
                s2_valid   <= 1'b1;
                s2_rd      <= s1_rd;
                s2_wdata   <= s1_wdata;
                s2_illegal <= !s1_legal;
            end else if (fire) begin
                s2_valid <= 1'b0;
            end

            if (fire) begin
                commit_count <= commit_count + CNT_W'(1);
            end
        end
    end

    // The S1 instruction word is pure payload, qualified by s1_valid.
    always_ff @(posedge clk) begin
        if (accept) begin
            s1_instr <= instr;
        end
    end

    // -------------------------------------------------------------------------
    // Shadow regfile. Not cleared by reset. The writeback assignment comes last
    // so it overrides a colliding seed write to the same index. A commit that
    // coincides with reset is discarded, so it does not write.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rf_init_we && (rf_init_addr != 5'd0)) begin
            rf[rf_init_addr] <= rf_init_data;
        end
        if (fire && !reset && !s2_illegal && (s2_rd != 5'd0)) begin
            rf[s2_rd] <= s2_wdata;
        end
    end

    // -------------------------------------------------------------------------
    // Commit outputs
    // -------------------------------------------------------------------------
    assign commit_valid   = s2_valid;
    assign commit_rd      = s2_rd;
    assign commit_wdata   = s2_wdata;
    assign commit_illegal = s2_illegal;

endmodule

// File: tb/tb_sodor5_itype_ref_exec.sv
// -----------------------------------------------------------------------------
// tb_sodor5_itype_ref_exec
//
// Self-checking bench for sodor5_itype_ref_exec. A behavioural model executes
// each accepted instruction in commit order against a model regfile. That
// in-order view covers forwarding without modelling the pipeline. Directed steps
// cover the architectural corner cases, followed by a randomized stream with
// random backpressure.
// -----------------------------------------------------------------------------
module tb_sodor5_itype_ref_exec;

    // ---------------------------------------------------------------- clock/reset
    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready;
    logic        rf_init_we;
    logic [4:0]  rf_init_addr;
    logic [31:0] rf_init_data;
    logic        commit_valid;
    logic        commit_ready;
    logic [4:0]  commit_rd;
    logic [31:0] commit_wdata;
    logic        commit_illegal;
    logic [31:0] commit_count;

    always #5 clk = ~clk;

    sodor5_itype_ref_exec #(
        .XLEN  (32),
        .NREGS (32),
        .CNT_W (32)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_ready    (instr_ready),
        .rf_init_we     (rf_init_we),
        .rf_init_addr   (rf_init_addr),
        .rf_init_data   (rf_init_data),
        .commit_valid   (commit_valid),
        .commit_ready   (commit_ready),
        .commit_rd      (commit_rd),
        .commit_wdata   (commit_wdata),
        .commit_illegal (commit_illegal),
        .commit_count   (commit_count)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------------------------------------------------------- scoreboard
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] ref_rf [32];
    logic [31:0] exp_q [$];      // accepted, not yet committed instruction words
    logic [31:0] ref_cnt = 0;

    logic        last_acc  = 1'b0;
    logic        last_fire = 1'b0;
    logic [4:0]  last_rd   = '0;
    logic [31:0] last_wd   = '0;
    logic        last_ill  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc(input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [11:0] imm);
        return {imm, rs1, f3, rd, 7'b0010011};
    endfunction

    // Architectural meaning of one OP-IMM instruction, from the ISA rules.
    function automatic void ref_exec(input logic [31:0] ins, output logic [4:0] rd,
                                     output logic [31:0] wd, output logic ill);
        logic [31:0] a;
        logic [31:0] imm;
        logic [4:0]  sh;
        logic [6:0]  hi;
        rd  = ins[11:7];
        a   = (ins[19:15] == 5'd0) ? 32'd0 : ref_rf[ins[19:15]];
        imm = {{20{ins[31]}}, ins[31:20]};
        sh  = ins[24:20];
        hi  = ins[31:25];
        ill = (ins[6:0] != 7'h13);
        wd  = 32'd0;
        case (ins[14:12])
            3'd0: wd = a + imm;
            3'd2: wd = (int'(a) < int'(imm)) ? 32'd1 : 32'd0;
            3'd3: wd = (a < imm) ? 32'd1 : 32'd0;
            3'd4: wd = a ^ imm;
            3'd6: wd = a | imm;
            3'd7: wd = a & imm;
            3'd1: begin
                if (hi != 7'd0) ill = 1'b1;
                else            wd  = a << sh;
            end
            default: begin
                if (hi == 7'd0)       wd = a >> sh;
                else if (hi == 7'h20) wd = (a >> sh) | (a[31] ? ~(32'hffff_ffff >> sh) : 32'd0);
                else                  ill = 1'b1;
            end
        endcase
        if (ill || rd == 5'd0) wd = 32'd0;
    endfunction

    // One clock cycle. Inputs are already driven at the negedge. The handshake
    // is sampled just after that, the model is updated, then the bench moves to
    // the next negedge and checks the counter.
    task automatic tick();
        logic [4:0]  e_rd;
        logic [31:0] e_wd;
        logic        e_ill;
        logic [31:0] ins;
        logic        wb;
        wb = 1'b0;
        e_rd = '0; e_wd = '0; e_ill = 1'b0;
        #1;
        last_acc  = instr_valid && instr_ready;
        last_fire = commit_valid && commit_ready;
        if (reset) begin
            exp_q.delete();
            ref_cnt   = 0;
            last_acc  = 1'b0;
            last_fire = 1'b0;
            if (rf_init_we && rf_init_addr != 5'd0) ref_rf[rf_init_addr] = rf_init_data;
        end else begin
            if (last_fire) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_commit", 32'(commit_valid), 32'd0);
                end else begin
                    ins = exp_q.pop_front();
                    ref_exec(ins, e_rd, e_wd, e_ill);
                    last_rd  = commit_rd;
                    last_wd  = commit_wdata;
                    last_ill = commit_illegal;
                    chk("sb_rd", 32'(commit_rd), 32'(e_rd));
                    chk("sb_wdata", commit_wdata, e_wd);
                    chk("sb_illegal", 32'(commit_illegal), 32'(e_ill));
                    ref_cnt = ref_cnt + 1;
                    wb = 1'b1;
                end
            end
            if (rf_init_we && rf_init_addr != 5'd0) ref_rf[rf_init_addr] = rf_init_data;
            if (wb && !e_ill && e_rd != 5'd0) ref_rf[e_rd] = e_wd;
            if (last_acc) exp_q.push_back(instr);
        end
        @(posedge clk);
        @(negedge clk);
        chk("commit_count", commit_count, ref_cnt);
    endtask

    // ---------------------------------------------------------------- driver tasks
    task automatic seed(input logic [4:0] addr, input logic [31:0] data);
        rf_init_we   = 1'b1;
        rf_init_addr = addr;
        rf_init_data = data;
        tick();
        rf_init_we   = 1'b0;
    endtask

    task automatic send(input logic [31:0] ins);
        int budget;
        budget      = 20;
        instr_valid = 1'b1;
        instr       = ins;
        do begin
            tick();
            budget--;
        end while (!last_acc && budget > 0);
        if (!last_acc) chk("send_timeout", 32'(last_acc), 32'd1);
        instr_valid = 1'b0;
    endtask

    task automatic drain();
        int budget;
        budget       = 30;
        instr_valid  = 1'b0;
        commit_ready = 1'b1;
        while (exp_q.size() != 0 && budget > 0) begin
            tick();
            budget--;
        end
        #1;
        chk("drain_idle", 32'(commit_valid), 32'd0);
    endtask

    task automatic run_one(input string tag, input logic [31:0] ins,
                           input logic [31:0] exp_wd, input logic exp_ill);
        commit_ready = 1'b1;
        send(ins);
        drain();
        chk({tag, "_wdata"}, last_wd, exp_wd);
        chk({tag, "_illegal"}, 32'(last_ill), 32'(exp_ill));
    endtask

    function automatic logic [31:0] rand_instr();
        int         k;
        logic [2:0] f3;
        logic [11:0] imm;
        k = $urandom_range(0, 15);
        if (k == 0) return $urandom();
        f3  = 3'($urandom_range(0, 7));
        imm = 12'($urandom());
        if (f3 == 3'd1 && k > 2) imm[11:5] = 7'h00;
        if (f3 == 3'd5 && k > 2) imm[11:5] = k[0] ? 7'h20 : 7'h00;
        return enc(f3, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), imm);
    endfunction

    // ---------------------------------------------------------------- stimulus
    initial begin
        logic [31:0] ofr [3];
        logic [31:0] cnt0;
        int          idx;

        reset        = 1'b1;
        instr_valid  = 1'b0;
        instr        = '0;
        rf_init_we   = 1'b0;
        rf_init_addr = '0;
        rf_init_data = '0;
        commit_ready = 1'b0;
        for (int r = 0; r < 32; r++) ref_rf[r] = 32'd0;

        @(negedge clk);
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("rst_commit_valid", 32'(commit_valid), 32'd0);
        chk("rst_commit_rd", 32'(commit_rd), 32'd0);
        chk("rst_commit_wdata", commit_wdata, 32'd0);
        chk("rst_commit_illegal", 32'(commit_illegal), 32'd0);
        chk("rst_instr_ready", 32'(instr_ready), 32'd1);

        for (int r = 1; r < 32; r++) seed(5'(r), $urandom());

        // 1: seed x5, ADDI x6,x5,-1 with two-cycle latency
        seed(5'd5, 32'h0000_0010);
        commit_ready = 1'b1;
        instr_valid  = 1'b1;
        instr        = 32'hfff2_8313;
        tick();
        chk("t1_accept", 32'(last_acc), 32'd1);
        instr_valid = 1'b0;
        #1;
        chk("t1_not_yet", 32'(commit_valid), 32'd0);
        tick();
        #1;
        chk("t1_valid", 32'(commit_valid), 32'd1);
        chk("t1_rd", 32'(commit_rd), 32'd6);
        chk("t1_wdata", commit_wdata, 32'h0000_000f);
        chk("t1_illegal", 32'(commit_illegal), 32'd0);
        drain();

        // 2: back-to-back dependency through the S2 bypass, no bubble
        instr_valid = 1'b1;
        instr       = enc(3'd0, 5'd1, 5'd0, 12'd5);
        tick();
        chk("t2_accept_a", 32'(last_acc), 32'd1);
        instr = enc(3'd0, 5'd2, 5'd1, 12'd3);
        tick();
        chk("t2_accept_b", 32'(last_acc), 32'd1);
        instr_valid = 1'b0;
        tick();
        chk("t2_fire_a", 32'(last_fire), 32'd1);
        chk("t2_wdata_a", last_wd, 32'd5);
        tick();
        chk("t2_fire_b", 32'(last_fire), 32'd1);
        chk("t2_rd_b", 32'(last_rd), 32'd2);
        chk("t2_wdata_b", last_wd, 32'd8);
        drain();

        // 3: shifts
        seed(5'd7, 32'h8000_0000);
        run_one("t3_srai", enc(3'd5, 5'd8, 5'd7, 12'h404), 32'hf800_0000, 1'b0);
        run_one("t3_srli", enc(3'd5, 5'd8, 5'd7, 12'h004), 32'h0800_0000, 1'b0);
        seed(5'd9, 32'h0000_0abc);
        run_one("t3_slli_bad", enc(3'd1, 5'd9, 5'd7, 12'h020), 32'd0, 1'b1);
        run_one("t3_x9_kept", enc(3'd0, 5'd10, 5'd9, 12'd0), 32'h0000_0abc, 1'b0);

        // 4: compares and the x0 destination/source
        seed(5'd3, 32'hffff_ffff);
        run_one("t4_slti", enc(3'd2, 5'd4, 5'd3, 12'h000), 32'd1, 1'b0);
        run_one("t4_sltiu", enc(3'd3, 5'd4, 5'd3, 12'hfff), 32'd0, 1'b0);
        run_one("t4_addi_x0", enc(3'd0, 5'd0, 5'd3, 12'd1), 32'd0, 1'b0);
        chk("t4_rd_x0", 32'(last_rd), 32'd0);
        seed(5'd0, 32'h0000_dead);
        run_one("t4_x0_reads0", enc(3'd0, 5'd11, 5'd0, 12'd7), 32'd7, 1'b0);

        // 5: backpressure with three instructions offered
        cnt0         = ref_cnt;
        commit_ready = 1'b0;
        ofr[0]       = enc(3'd0, 5'd14, 5'd0, 12'd100);
        ofr[1]       = enc(3'd0, 5'd15, 5'd14, 12'd1);
        ofr[2]       = enc(3'd4, 5'd16, 5'd15, 12'h0ff);
        idx          = 0;
        for (int c = 0; c < 5; c++) begin
            instr_valid = 1'b1;
            instr       = ofr[idx];
            tick();
            if (last_acc) idx++;
            if (c >= 1) begin
                chk("t5_ready_low", 32'(instr_ready), 32'd0);
                chk("t5_hold_rd", 32'(commit_rd), 32'd14);
                chk("t5_hold_wdata", commit_wdata, 32'd100);
            end
        end
        chk("t5_accepted", 32'(idx), 32'd2);
        commit_ready = 1'b1;
        send(ofr[2]);
        drain();
        chk("t5_count", commit_count, cnt0 + 32'd3);
        chk("t5_last_wdata", last_wd, 32'd101 ^ 32'h0ff);

        // writeback and seed write to the same index on one edge
        commit_ready = 1'b0;
        instr_valid  = 1'b1;
        instr        = enc(3'd0, 5'd9, 5'd0, 12'h055);
        tick();
        instr_valid  = 1'b0;
        tick();
        commit_ready = 1'b1;
        rf_init_we   = 1'b1;
        rf_init_addr = 5'd9;
        rf_init_data = 32'hdead_beef;
        tick();
        rf_init_we   = 1'b0;
        run_one("collide", enc(3'd0, 5'd10, 5'd9, 12'd0), 32'h0000_0055, 1'b0);

        // 6: reset with both stages full
        seed(5'd12, 32'h0000_1234);
        commit_ready = 1'b0;
        instr_valid  = 1'b1;
        instr        = enc(3'd0, 5'd12, 5'd0, 12'h077);
        tick();
        instr        = enc(3'd0, 5'd13, 5'd0, 12'd1);
        tick();
        instr_valid  = 1'b0;
        reset        = 1'b1;
        tick();
        reset        = 1'b0;
        #1;
        chk("t6_valid", 32'(commit_valid), 32'd0);
        chk("t6_count", commit_count, 32'd0);
        chk("t6_ready", 32'(instr_ready), 32'd1);
        run_one("t6_x12_kept", enc(3'd0, 5'd17, 5'd12, 12'd0), 32'h0000_1234, 1'b0);
        run_one("t6_all_ones", 32'hffff_ffff, 32'd0, 1'b1);
        chk("t6_all_ones_rd", 32'(last_rd), 32'd31);

        // randomized stream with random backpressure
        for (int c = 0; c < 400; c++) begin
            instr_valid  = ($urandom_range(0, 3) != 0);
            instr        = rand_instr();
            commit_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
